// File: rtl/rv_multicycle_core.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXECUTE/[MEM]/WB, 4 cycles per instruction (5 for LW/SW) plus memory waits.
// A single ready/valid memory port serves fetches and data; the core stalls in FETCH/MEM until mem_ready completes the request.
module rv_multicycle_core #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              error,
  output logic [31:0]       instret,
  input  logic [4:0]        dbg_sel,
  output logic [XLEN-1:0]   dbg_val
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } insn_t;

  state_t          state, state_n;
  insn_t           ir;
  logic [XLEN-1:0] pc, res, npc;
  logic            wr;
  logic [XLEN-1:0] regs [32];

  logic is_op, is_opimm, is_lui, is_auipc, is_load, is_store;
  logic is_branch, is_jal, is_jalr, is_sys, legal, sh_rsvd;
  logic [XLEN-1:0] rs1_v, rs2_v;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] alu_b, alu, pc4, br_tgt, jalr_sum, ls_addr;
  logic [SHW-1:0]  shamt;
  logic            taken;
  logic [XLEN-1:0] ex_res, ex_npc;
  logic            ex_wr, ex_misalign;
  logic            unused_bits;

  assign is_op     = (ir.opcode == OPC_OP);
  assign is_opimm  = (ir.opcode == OPC_OPIMM);
  assign is_lui    = (ir.opcode == OPC_LUI);
  assign is_auipc  = (ir.opcode == OPC_AUIPC);
  assign is_load   = (ir.opcode == OPC_LOAD);
  assign is_store  = (ir.opcode == OPC_STORE);
  assign is_branch = (ir.opcode == OPC_BRANCH);
  assign is_jal    = (ir.opcode == OPC_JAL);
  assign is_jalr   = (ir.opcode == OPC_JALR);
  assign is_sys    = (ir.opcode == OPC_SYSTEM);

  // Shift-immediate bits above shamt must be zero except the SRAI select bit (ir[30]).
  assign sh_rsvd = (XLEN == 64) ? (ir.funct7[6] | (|ir.funct7[4:1]))
                                : (ir.funct7[6] | (|ir.funct7[4:0]));

  always_comb begin
    legal = 1'b0;
    case (ir.opcode)
      OPC_OP:     legal = (ir.funct7 == 7'b0000000) ||
                          (ir.funct7 == 7'b0100000 && (ir.funct3 == 3'b000 || ir.funct3 == 3'b101));
      OPC_OPIMM: begin
        case (ir.funct3)
          3'b001:  legal = !sh_rsvd && !ir.funct7[5];
          3'b101:  legal = !sh_rsvd;
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (ir.funct3 == 3'b000);
      OPC_BRANCH: legal = (ir.funct3 != 3'b010) && (ir.funct3 != 3'b011);
      OPC_LOAD, OPC_STORE: legal = (ir.funct3 == 3'b010);
      // Only ECALL (imm 0) and EBREAK (imm 1) with all other fields zero.
      OPC_SYSTEM: legal = (ir[31:21] == 11'd0) && (ir[19:7] == 13'd0);
      default:    legal = 1'b0;
    endcase
  end

  assign rs1_v = regs[ir.rs1];
  assign rs2_v = regs[ir.rs2];

  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  assign alu_b = is_op ? rs2_v : imm_i;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu = '0;
    case (ir.funct3)
      3'b000:  alu = (is_op && ir.funct7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu = rs1_v << shamt;
      3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, rs1_v < alu_b};
      3'b100:  alu = rs1_v ^ alu_b;
      3'b101:  alu = ir[30] ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'b110:  alu = rs1_v | alu_b;
      default: alu = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (ir.funct3)
      3'b000:  taken = (rs1_v == rs2_v);
      3'b001:  taken = (rs1_v != rs2_v);
      3'b100:  taken = ($signed(rs1_v) <  $signed(rs2_v));
      3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110:  taken = (rs1_v <  rs2_v);
      3'b111:  taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  assign pc4      = pc + XLEN'(4);
  assign br_tgt   = pc + imm_b;
  assign jalr_sum = rs1_v + imm_i;
  assign ls_addr  = rs1_v + (is_store ? imm_s : imm_i);
  assign unused_bits = ^{ls_addr[XLEN-1:ADDR_W+2], jalr_sum[0]};

  always_comb begin
    ex_res      = alu;
    ex_npc      = pc4;
    ex_wr       = 1'b0;
    ex_misalign = 1'b0;
    if (is_op || is_opimm) begin
      ex_wr = 1'b1;
    end else if (is_lui) begin
      ex_res = imm_u;
      ex_wr  = 1'b1;
    end else if (is_auipc) begin
      ex_res = pc + imm_u;
      ex_wr  = 1'b1;
    end else if (is_jal) begin
      ex_res      = pc4;
      ex_npc      = pc + imm_j;
      ex_wr       = 1'b1;
      ex_misalign = ex_npc[1];
    end else if (is_jalr) begin
      ex_res      = pc4;
      ex_npc      = {jalr_sum[XLEN-1:1], 1'b0};
      ex_wr       = 1'b1;
      ex_misalign = ex_npc[1];
    end else if (is_branch) begin
      // Only a taken branch can fault on its target.
      if (taken) ex_npc = br_tgt;
      ex_misalign = taken && br_tgt[1];
    end else if (is_load || is_store) begin
      ex_wr       = is_load;
      ex_misalign = (ls_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (mem_req && mem_ready) state_n = S_DECODE;
      S_DECODE: state_n = legal ? S_EXEC : S_ERROR;
      S_EXEC: begin
        if (is_sys)                     state_n = S_HALT;
        else if (ex_misalign)           state_n = S_ERROR;
        else if (is_load || is_store)   state_n = S_MEM;
        else                            state_n = S_WB;
      end
      S_MEM:    if (mem_req && mem_ready) state_n = S_WB;
      S_WB:     state_n = S_FETCH;
      default:  state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      res       <= '0;
      npc       <= '0;
      wr        <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instret   <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // Only reached with mem_req low straight out of reset.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_W+1:2];
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= insn_t'(mem_rdata[31:0]);
          end
        end
        S_EXEC: begin
          res <= ex_res;
          npc <= ex_npc;
          wr  <= ex_wr;
          if (state_n == S_MEM) begin
            mem_req  <= 1'b1;
            mem_we   <= is_store;
            mem_addr <= ls_addr[ADDR_W+1:2];
            if (is_store) mem_wdata <= rs2_v;
          end
          if (state_n == S_HALT) instret <= instret + 32'd1;
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) res <= XLEN'($signed(mem_rdata[31:0]));
          end
        end
        S_WB: begin
          if (wr && ir.rd != 5'd0) regs[ir.rd] <= res;
          pc       <= npc;
          instret  <= instret + 32'd1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= npc[ADDR_W+1:2];
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state == S_HALT);
  assign error   = (state == S_ERROR);
  assign dbg_val = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Parametrised multicycle RV32I-subset processor core: the next generation of the board-level FETCH/DECODE/EXECUTE/UPDATE sequencer. It adds a variable-latency ready/valid memory port shared by instruction and data accesses, loads and stores, branches and jumps, and halt and error reporting. It sits below the board top level, which provides the memory (`processor_memory` or SDRAM bridge), the seven-segment debug display and the LEDs.

## Interface
Parameters:
- `XLEN`, 32 — datapath and register width; legal values 32 or 64; instructions are always 32 bits.
- `ADDR_W`, 16 — width of the word address on the memory port.
- `RESET_PC`, 0 — byte address of the first fetch; must be a multiple of 4.

Ports (reset `rst` is asynchronous, active-low; clock is `clk`):
- `clk` in 1 — clock; all state changes on the rising edge.
- `rst` in 1 — asynchronous active-low reset.
- `mem_req` out 1 — memory request, held until accepted.
- `mem_we` out 1 — 1 = store, 0 = read.
- `mem_addr` out ADDR_W — word address (byte address >> 2).
- `mem_wdata` out XLEN — store data.
- `mem_rdata` in XLEN — read data; valid in the cycle `mem_ready`=1.
- `mem_ready` in 1 — completes the pending request.
- `halted` out 1 — ECALL or EBREAK was executed.
- `error` out 1 — illegal instruction or misaligned access.
- `instret` out 32 — count of retired instructions.
- `dbg_sel` in 5 — register index for the debug read port.
- `dbg_val` out XLEN — combinational read of `x[dbg_sel]`.

## Operation
- **States:**
  - FETCH → DECODE when `mem_ready`=1; stays in FETCH otherwise.
  - DECODE → EXECUTE.
  - EXECUTE → MEM for LOAD/STORE; → WB for all other legal instructions.
  - MEM → WB on `mem_ready`; stays in MEM otherwise.
  - WB → FETCH.
  - HALT and ERROR are terminal; only reset exits them.
- **Supported instructions:** OP, OP-IMM (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), LUI, AUIPC, LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR, ECALL, EBREAK.
- **Illegal instructions:** any other opcode/funct combination is detected in DECODE and moves to ERROR.
- **Sign extension:** immediates are sign-extended to XLEN.
- **Shift amount:** `rs2[4:0]` when XLEN=32, `rs2[5:0]` when XLEN=64. SLT is signed; SLTU is unsigned. Arithmetic wraps modulo 2^XLEN.
- **LW:** when XLEN=64, `mem_rdata[31:0]` is sign-extended.
- **SW:** `mem_wdata` carries rs2 unmodified; the memory stores the low 32 bits.
- **Register file:** 32×XLEN. x0 reads 0 and writes to it are discarded. The file is written only in WB, and only when rd≠0 and the instruction writes rd. A `dbg_sel` read of x0 returns 0.
- **PC update (in WB):**
  - pc+4 by default.
  - Taken branch or JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR write pc+4 to rd.
- **Alignment errors:** a branch or jump target with bit 1 set, or a load/store byte address with bits [1:0]≠0, moves to ERROR from EXECUTE. No memory request is issued, pc is not updated and no register is written.
- **Address truncation:** byte addresses are truncated to ADDR_W+2 bits; `mem_addr` = addr[ADDR_W+1:2], so addresses wrap silently.
- **ECALL/EBREAK:** in EXECUTE, move to HALT and set `halted`=1. `instret` counts the ECALL/EBREAK as retired; pc is not updated.
- **`instret`:** increments by 1 in each WB cycle and in the HALT transition. It wraps at 2^32.

## Timing
- **Reset values:**
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `halted`=0, `error`=0, `instret`=0.
  - pc=RESET_PC, all registers 0, state FETCH.
- **First cycle after reset:** the first rising edge after `rst` deasserts enters FETCH with `mem_req`=1.
- **Request handshake:**
  - `mem_req` is asserted in FETCH and MEM.
  - `mem_addr`, `mem_we` and `mem_wdata` are registered and stable for the whole time `mem_req`=1.
  - A transaction completes on the edge where `mem_req`=1 and `mem_ready`=1. `mem_rdata` is sampled on that edge.
  - `mem_req` is 0 in the following cycle, so there are no back-to-back requests.
- **Ready timing:** `mem_ready` may be 1 in the first cycle of a request (zero wait states). `mem_ready` while `mem_req`=0 is ignored.
- **Instruction latency with zero wait states:**
  - 4 cycles for ALU, LUI, AUIPC, branch and jump instructions.
  - 5 cycles for LW and SW.
  - Each wait cycle adds 1.
- **Fetched instruction:** held in a register from DECODE onward; a `mem_rdata` change after the handshake has no effect.
- **Terminal states:** in HALT and ERROR, `mem_req`=0. `halted` and `error` are sticky and mutually exclusive.
- **Reset mid-transaction:** an asynchronous `rst` during a pending request drops `mem_req` immediately. The memory must discard the request.

## Test plan
- **ALU and x0:** `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2`; `sltu x4,x1,x2`; `addi x0,x0,7`, all with zero wait states → x3=2, x4=1, x0=0, `instret`=5 after exactly 20 cycles.
- **Random wait states:** `mem_ready` delayed 0–7 random cycles on every request → register results identical to the zero-wait run; `mem_addr`, `mem_we` and `mem_wdata` never change while `mem_req`=1.
- **Store/load:** `sw x1,8(x0)` then `lw x5,8(x0)` with x1=0xDEADBEEF → write at `mem_addr`=2 with `mem_wdata`=0xDEADBEEF, then x5=0xDEADBEEF. With XLEN=64, x5=0xFFFFFFFFDEADBEEF.
- **Control flow:**
  - `bne x1,x2,-8` loop counting x1 from 0 to 3 exits with x1=3.
  - `jal x1,+12` at pc 0x20 → x1=0x24, next fetch at word address 0x0B.
  - `jalr` to target 0x31 → fetch at byte address 0x30.
- **Errors:**
  - Opcode 0x7F → `error`=1 after DECODE, no further `mem_req`.
  - `lw` from byte address 0x6 → `error`=1, no memory request, rd unchanged.
- **Halt and reset:**
  - `ecall` → `halted`=1 and `instret` incremented.
  - `rst` pulsed low mid-FETCH with `mem_ready` held low → `mem_req` drops 0 asynchronously; after release, fetch restarts at RESET_PC.
